q_table_writer: RTL and testbench

Writer side of the neighbor Q-table in node data memory. The mybest reader consumes three structures: the neighborCount word, the qValue table and the HCM table. This block maintains the first two, plus a neighbor-ID table kept in parallel with qValue. On each update it searches the ID table for the reporting neighbor, then either overwrites that neighbor's Q-value or appends a new entry and increments neighborCount.

---
 rtl/q_table_writer_pkg.sv | 23 ++
 rtl/q_table_writer.sv | 171 +++++++++++++++++
 tb/tb_q_table_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_table_writer_pkg.sv
// Shared constants and state encoding for the neighbor Q-table writer and the mybest reader.
// Addresses are word addresses into node data memory.
package q_table_writer_pkg;

    localparam int unsigned WORD_WIDTH    = 16;
    localparam int unsigned MAX_NEIGHBORS = 32;

    localparam logic [15:0] CNT_ADDR = 16'h068A;
    localparam logic [15:0] ID_BASE  = 16'h0188;
    localparam logic [15:0] Q_BASE   = 16'h01C8;
    localparam logic [15:0] HCM_BASE = 16'h0648;

    typedef enum logic [2:0] {
        ST_WAIT_EN = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD_CNT  = 3'd2,
        ST_SCAN    = 3'd3,
        ST_WR_Q    = 3'd4,
        ST_WR_ID   = 3'd5,
        ST_WR_CNT  = 3'd6
    } state_t;

endpackage

// File: rtl/q_table_writer.sv
// Neighbor Q-table writer: searches the ID table for the reporting neighbor, then overwrites its
// Q-value or appends a new entry (Q, ID, then neighborCount last so a reset mid-append is harmless).
module q_table_writer #(
    parameter int unsigned WORD_WIDTH    = q_table_writer_pkg::WORD_WIDTH,
    parameter int unsigned MAX_NEIGHBORS = q_table_writer_pkg::MAX_NEIGHBORS,
    parameter logic [WORD_WIDTH-1:0] CNT_ADDR = WORD_WIDTH'(q_table_writer_pkg::CNT_ADDR),
    parameter logic [WORD_WIDTH-1:0] ID_BASE  = WORD_WIDTH'(q_table_writer_pkg::ID_BASE),
    parameter logic [WORD_WIDTH-1:0] Q_BASE   = WORD_WIDTH'(q_table_writer_pkg::Q_BASE)
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] neighbor_id,
    input  logic [WORD_WIDTH-1:0] q_value_in,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  done,
    output logic                  hit,
    output logic                  full
);

    import q_table_writer_pkg::*;

    // Count must hold 0..MAX_NEIGHBORS inclusive.
    localparam int unsigned CNT_W = $clog2(MAX_NEIGHBORS + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      idx, idx_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CNT_W-1:0]      cnt_sat_c;
    logic                  match, match_nxt;
    logic [WORD_WIDTH-1:0] id_q, id_nxt;
    logic [WORD_WIDTH-1:0] q_q, q_nxt;

    logic [WORD_WIDTH-1:0] address_nxt, data_out_nxt;
    logic                  wr_en_nxt, done_nxt, hit_nxt, full_nxt;
    logic [WORD_WIDTH-1:0] base_c;
    logic [CNT_W-1:0]      idx_sel_c;

    // Stored counts above capacity are treated as a full table.
    assign cnt_sat_c = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? CNT_W'(MAX_NEIGHBORS)
                                                               : data_in[CNT_W-1:0];

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state    <= ST_WAIT_EN;
            idx      <= '0;
            cnt      <= '0;
            match    <= 1'b0;
            id_q     <= '0;
            q_q      <= '0;
            address  <= CNT_ADDR;
            data_out <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            hit      <= 1'b0;
            full     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            match    <= match_nxt;
            id_q     <= id_nxt;
            q_q      <= q_nxt;
            address  <= address_nxt;
            data_out <= data_out_nxt;
            wr_en    <= wr_en_nxt;
            done     <= done_nxt;
            hit      <= hit_nxt;
            full     <= full_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        match_nxt = match;
        id_nxt    = id_q;
        q_nxt     = q_q;
        case (state)
            ST_WAIT_EN: begin
                if (en) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RD_CNT;
                    id_nxt    = neighbor_id;
                    q_nxt     = q_value_in;
                    match_nxt = 1'b0;
                end
            end
            ST_RD_CNT: begin
                cnt_nxt   = cnt_sat_c;
                idx_nxt   = '0;
                match_nxt = 1'b0;
                state_nxt = (cnt_sat_c == '0) ? ST_WR_Q : ST_SCAN;
            end
            ST_SCAN: begin
                if (data_in == id_q) begin
                    state_nxt = ST_WR_Q;
                    match_nxt = 1'b1;
                end else if ((idx + CNT_W'(1)) < cnt) begin
                    idx_nxt = idx + CNT_W'(1);
                end else if (cnt == CNT_W'(MAX_NEIGHBORS)) begin
                    state_nxt = ST_WAIT_EN;
                end else begin
                    state_nxt = ST_WR_Q;
                    idx_nxt   = cnt;
                end
            end
            ST_WR_Q:   state_nxt = match ? ST_WAIT_EN : ST_WR_ID;
            ST_WR_ID:  state_nxt = ST_WR_CNT;
            ST_WR_CNT: state_nxt = ST_WAIT_EN;
            default:   state_nxt = ST_WAIT_EN;
        endcase
    end

    // Registered-output next values, keyed on the state being entered.
    always_comb begin
        base_c       = CNT_ADDR;
        idx_sel_c    = '0;
        wr_en_nxt    = 1'b0;
        data_out_nxt = '0;
        done_nxt     = done;
        hit_nxt      = hit;
        full_nxt     = full;
        case (state_nxt)
            ST_SCAN: begin
                base_c    = ID_BASE;
                idx_sel_c = idx_nxt;
            end
            ST_WR_Q: begin
                base_c       = Q_BASE;
                idx_sel_c    = idx_nxt;
                wr_en_nxt    = 1'b1;
                data_out_nxt = q_q;
            end
            ST_WR_ID: begin
                base_c       = ID_BASE;
                idx_sel_c    = idx_nxt;
                wr_en_nxt    = 1'b1;
                data_out_nxt = id_q;
            end
            ST_WR_CNT: begin
                wr_en_nxt    = 1'b1;
                data_out_nxt = WORD_WIDTH'(cnt) + WORD_WIDTH'(1);
            end
            default: ;
        endcase

        if (state == ST_WAIT_EN && en) begin
            done_nxt = 1'b0;
            hit_nxt  = 1'b0;
            full_nxt = 1'b0;
        end else if (state != ST_WAIT_EN && state_nxt == ST_WAIT_EN) begin
            done_nxt = 1'b1;
            hit_nxt  = match;
            full_nxt = (state == ST_SCAN);
        end
    end

    // Single address adder shared by all table accesses.
    assign address_nxt = base_c + WORD_WIDTH'({idx_sel_c, 1'b0});

endmodule

// File: tb/tb_q_table_writer.sv
// Directed bench for q_table_writer against a word-addressed memory model with a write log.
`timescale 1ns/1ps
module tb_q_table_writer;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        start;
    logic [15:0] neighbor_id;
    logic [15:0] q_value_in;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        wr_en;
    logic        done;
    logic        hit;
    logic        full;

    logic [15:0] mem [0:65535];
    logic [15:0] wlog_a[$];
    logic [15:0] wlog_d[$];

    int passed = 0;
    int total  = 0;

    q_table_writer dut (
        .clock       (clk),
        .nrst        (nrst),
        .en          (en),
        .start       (start),
        .neighbor_id (neighbor_id),
        .q_value_in  (q_value_in),
        .data_in     (data_in),
        .address     (address),
        .data_out    (data_out),
        .wr_en       (wr_en),
        .done        (done),
        .hit         (hit),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous read; writes commit at the edge unless reset drops them.
    assign data_in = mem[address];
    always @(posedge clk) begin
        if (wr_en && nrst) begin
            mem[address] <= data_out;
            wlog_a.push_back(address);
            wlog_d.push_back(data_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    task automatic load_table(input int count, input int n_ids, input logic [15:0] base_id);
        mem[16'h068A] = 16'(count);
        for (int i = 0; i < 40; i++) begin
            mem[16'h0188 + 16'(2 * i)] = (i < n_ids) ? base_id + 16'(i) : 16'h0000;
        end
    endtask

    // From WAIT_EN: re-arm, present start (E0), then count edges until done.
    task automatic run_update(input logic [15:0] id, input logic [15:0] q, output int edges);
        en = 1'b1;
        tick();
        en = 1'b0;
        clear_log();
        neighbor_id = id;
        q_value_in  = q;
        start       = 1'b1;
        tick();
        start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b0; start = 1'b0;
        neighbor_id = '0; q_value_in = '0;
        repeat (3) tick();
        total++;
        if ({address, data_out, wr_en, done, hit, full} !== {16'h068A, 16'h0000, 4'b0000})
            $display("FAIL reset_outputs: got addr=%h dout=%h we=%b done=%b hit=%b full=%b", address, data_out, wr_en, done, hit, full);
        else passed++;
        nrst = 1'b1;
        clear_log();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        total++;
        if (wlog_a.size() != 0 || done !== 1'b0 || address !== 16'h068A)
            $display("FAIL start_in_wait_en: writes=%0d done=%b addr=%h, want 0/0/068a", wlog_a.size(), done, address);
        else passed++;
    endtask

    task automatic test_append_empty();
        logic [15:0] ea [3];
        logic [15:0] ed [3];
        int edges;
        ea = '{16'h01C8, 16'h0188, 16'h068A};
        ed = '{16'h0120, 16'h0005, 16'h0001};
        load_table(0, 0, 16'h0);
        run_update(16'h0005, 16'h0120, edges);
        total++;
        if (edges != 4) $display("FAIL empty_done_edge: got E%0d want E4", edges);
        else passed++;
        total++;
        if (wlog_a.size() != 3) $display("FAIL empty_write_count: got %0d want 3", wlog_a.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= wlog_a.size() || wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i])
                $display("FAIL empty_write%0d: got [%h]=%h want [%h]=%h", i,
                         (i < wlog_a.size()) ? wlog_a[i] : 16'hxxxx, (i < wlog_d.size()) ? wlog_d[i] : 16'hxxxx, ea[i], ed[i]);
            else passed++;
        end
        total++;
        if ({hit, full, wr_en, address} !== {3'b000, 16'h068A})
            $display("FAIL empty_flags: got hit=%b full=%b we=%b addr=%h want 0 0 0 068a", hit, full, wr_en, address);
        else passed++;
    endtask

    task automatic test_hit();
        int edges;
        load_table(3, 0, 16'h0);
        mem[16'h0188] = 16'd7; mem[16'h018A] = 16'd9; mem[16'h018C] = 16'd5;
        run_update(16'h0009, 16'h0040, edges);
        total++;
        if (edges != 4) $display("FAIL hit_done_edge: got E%0d want E4", edges);
        else passed++;
        total++;
        if (wlog_a.size() != 1 || wlog_a[0] !== 16'h01CA || wlog_d[0] !== 16'h0040)
            $display("FAIL hit_write: got %0d writes, first [%h]=%h want 1 write [01ca]=0040", wlog_a.size(),
                     (wlog_a.size() > 0) ? wlog_a[0] : 16'hxxxx, (wlog_d.size() > 0) ? wlog_d[0] : 16'hxxxx);
        else passed++;
        total++;
        if ({hit, full, mem[16'h068A]} !== {2'b10, 16'h0003})
            $display("FAIL hit_flags: got hit=%b full=%b cnt=%h want 1 0 0003", hit, full, mem[16'h068A]);
        else passed++;
    endtask

    task automatic test_append_new();
        logic [15:0] ea [3];
        logic [15:0] ed [3];
        int edges;
        ea = '{16'h01CE, 16'h018E, 16'h068A};
        ed = '{16'h0123, 16'h000B, 16'h0004};
        run_update(16'h000B, 16'h0123, edges);
        total++;
        if (edges != 7) $display("FAIL append_done_edge: got E%0d want E7", edges);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wlog_a.size() != 3 || wlog_a[i] !== ea[i] || wlog_d[i] !== ed[i])
                $display("FAIL append_write%0d: got %0d writes, [%h]=%h want [%h]=%h", i, wlog_a.size(),
                         (i < wlog_a.size()) ? wlog_a[i] : 16'hxxxx, (i < wlog_d.size()) ? wlog_d[i] : 16'hxxxx, ea[i], ed[i]);
            else passed++;
        end
        total++;
        if ({hit, full} !== 2'b00) $display("FAIL append_flags: got hit=%b full=%b want 0 0", hit, full);
        else passed++;
    endtask

    task automatic test_full();
        logic [15:0] counts [2];
        int edges;
        counts = '{16'h0020, 16'h0040};
        for (int r = 0; r < 2; r++) begin
            load_table(int'(counts[r]), 32, 16'h0100);
            run_update(16'h7777, 16'h0055, edges);
            total++;
            if (edges != 33) $display("FAIL full%0d_done_edge: got E%0d want E33", r, edges);
            else passed++;
            total++;
            if (wlog_a.size() != 0 || {hit, full, wr_en, address} !== {3'b010, 16'h068A})
                $display("FAIL full%0d_response: writes=%0d hit=%b full=%b we=%b addr=%h want 0 0 1 0 068a",
                         r, wlog_a.size(), hit, full, wr_en, address);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_append();
        int edges;
        load_table(3, 0, 16'h0);
        mem[16'h0188] = 16'd7; mem[16'h018A] = 16'd9; mem[16'h018C] = 16'd5;
        en = 1'b1; tick(); en = 1'b0;
        clear_log();
        neighbor_id = 16'h000B; q_value_in = 16'h0321; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        total++;
        if ({wr_en, address, data_out} !== {1'b1, 16'h018E, 16'h000B})
            $display("FAIL mid_in_wr_id: got we=%b addr=%h dout=%h want 1 018e 000b", wr_en, address, data_out);
        else passed++;
        nrst = 1'b0;
        tick();
        total++;
        if ({address, data_out, wr_en, done, hit, full} !== {16'h068A, 16'h0000, 4'b0000})
            $display("FAIL mid_reset_outputs: got addr=%h dout=%h we=%b done=%b hit=%b full=%b", address, data_out, wr_en, done, hit, full);
        else passed++;
        total++;
        if (wlog_a.size() != 1 || mem[16'h068A] !== 16'h0003 || mem[16'h018E] !== 16'h0000)
            $display("FAIL mid_reset_memory: writes=%0d cnt=%h id3=%h want 1 0003 0000", wlog_a.size(), mem[16'h068A], mem[16'h018E]);
        else passed++;
        nrst = 1'b1;
        run_update(16'h000B, 16'h0321, edges);
        total++;
        if (edges != 7 || wlog_a.size() != 3 || mem[16'h068A] !== 16'h0004 || mem[16'h018E] !== 16'h000B || mem[16'h01CE] !== 16'h0321)
            $display("FAIL mid_retry: edge=E%0d writes=%0d cnt=%h id3=%h q3=%h want E7 3 0004 000b 0321",
                     edges, wlog_a.size(), mem[16'h068A], mem[16'h018E], mem[16'h01CE]);
        else passed++;
    endtask

    task automatic test_hold_and_rearm();
        int writes;
        clear_log();
        en = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            if (!done) writes = writes + 100;
        end
        start = 1'b0;
        total++;
        if (wlog_a.size() != 0 || writes != 0 || address !== 16'h068A)
            $display("FAIL hold_done: writes=%0d done_drops=%0d addr=%h want 0 0 068a", wlog_a.size(), writes / 100, address);
        else passed++;
        en = 1'b1; start = 1'b1;
        tick();
        en = 1'b0; start = 1'b0;
        total++;
        if ({done, hit, full} !== 3'b000) $display("FAIL rearm_clear: got done=%b hit=%b full=%b want 0 0 0", done, hit, full);
        else passed++;
        repeat (5) tick();
        total++;
        if (wlog_a.size() != 0 || done !== 1'b0 || address !== 16'h068A)
            $display("FAIL en_start_same_cycle: writes=%0d done=%b addr=%h want 0 0 068a", wlog_a.size(), done, address);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        test_reset();
        test_append_empty();
        test_hit();
        test_append_new();
        test_full();
        test_reset_mid_append();
        test_hold_and_rearm();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
